// File: rtl/logic_unit_pkg.sv
// Purpose : shared types and constants for the logic-unit arbiter slice.
// Latency : n/a (types only).
// Backpressure : n/a (types only).
package logic_unit_pkg;

   // Bitwise operation selected by a requester
   typedef enum logic [1:0] {
      LU_AND = 2'b00,
      LU_OR  = 2'b01,
      LU_XOR = 2'b10,
      LU_NOR = 2'b11
   } lu_op_t;

   // Result slot occupancy
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } lu_state_t;

   // Width of each optional per-requester grant counter
   localparam int LU_PERF_W = 16;

endpackage : logic_unit_pkg

// File: rtl/logic_op_unit.sv
// Purpose : bitwise AND/OR/XOR/NOR of two DATA_W operands.
// Latency : combinational, zero cycles.
// Backpressure : none; pure function of its inputs.
module logic_op_unit
   import logic_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  lu_op_t            op_i,
   output logic [DATA_W-1:0] s_o
);

   // Select the bitwise result for the requested operation
   always_comb begin
      s_o = '0;
      case (op_i)
         LU_AND:  s_o = a_i & b_i;
         LU_OR:   s_o = a_i | b_i;
         LU_XOR:  s_o = a_i ^ b_i;
         LU_NOR:  s_o = ~(a_i | b_i);
         default: s_o = '0;
      endcase
   end

endmodule : logic_op_unit

// File: rtl/logic_unit_arbiter.sv
// Purpose : round-robin share of one bitwise logic unit among N_REQ requesters (optional grant counters under LOGIC_ARB_PERF_EN).
// Latency : 1 cycle from accepted request to registered result.
// Backpressure : slot full and consumer not ready -> no grants, result held; drain and refill in the same cycle.
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic [N_REQ-1:0]                 req_valid_i,
   output logic [N_REQ-1:0]                 req_ready_o,
   input  logic [N_REQ-1:0][1:0]            req_op_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]     req_a_i,
   input  logic [N_REQ-1:0][DATA_W-1:0]     req_b_i,
   output logic                             rsp_valid_o,
   input  logic                             rsp_ready_i,
   output logic [DATA_W-1:0]                rsp_data_o,
   output logic [$clog2(N_REQ)-1:0]         rsp_id_o
`ifdef LOGIC_ARB_PERF_EN
   ,
   output logic [N_REQ-1:0][LU_PERF_W-1:0]  perf_grant_o
`endif
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int IW1  = ID_W + 1;
   localparam logic [ID_W:0]   N_REQ_W = IW1'(N_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

   lu_state_t             state_q;
   logic [ID_W-1:0]       ptr_q;
   logic [ID_W-1:0]       gnt_idx;
   logic [ID_W-1:0]       ptr_next;
   logic                  gnt_found;
   logic                  can_accept;
   logic                  xfer;
   logic [ID_W:0]         cand;
   logic [DATA_W-1:0]     op_result;

   // Slot is free, or is being drained this very cycle
   assign can_accept = (state_q == ST_EMPTY) || rsp_ready_i;
   assign xfer       = gnt_found && can_accept;
   assign ptr_next   = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);

   // First valid requester at or after the round-robin pointer, modulo N_REQ
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr_q} + IW1'(i);
         if (cand >= N_REQ_W) begin
            cand = cand - N_REQ_W;
         end
         if (!gnt_found && req_valid_i[cand[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[ID_W-1:0];
         end
      end
   end

   // One-hot accept to the winner; forced low while reset is asserted
   always_comb begin
      req_ready_o = '0;
      if (rst_n_i && xfer) begin
         req_ready_o[gnt_idx] = 1'b1;
      end
   end

   // Single shared datapath fed by the grant mux
   logic_op_unit #(
      .DATA_W (DATA_W)
   ) u_op (
      .a_i  (req_a_i[gnt_idx]),
      .b_i  (req_b_i[gnt_idx]),
      .op_i (lu_op_t'(req_op_i[gnt_idx])),
      .s_o  (op_result)
   );

   // Slot FSM: load on transfer, drain on consumer accept, hold otherwise
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_EMPTY;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_id_o    <= '0;
         ptr_q       <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (xfer) begin
                  state_q     <= ST_FULL;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= op_result;
                  rsp_id_o    <= gnt_idx;
                  ptr_q       <= ptr_next;
               end
            end
            ST_FULL: begin
               if (rsp_ready_i) begin
                  if (xfer) begin
                     rsp_data_o <= op_result;
                     rsp_id_o   <= gnt_idx;
                     ptr_q      <= ptr_next;
                  end else begin
                     state_q     <= ST_EMPTY;
                     rsp_valid_o <= 1'b0;
                  end
               end
            end
            default: begin
               state_q     <= ST_EMPTY;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef LOGIC_ARB_PERF_EN
   // Per-requester saturating count of accepted requests
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         perf_grant_o <= '0;
      end else if (xfer && (perf_grant_o[gnt_idx] != {LU_PERF_W{1'b1}})) begin
         perf_grant_o[gnt_idx] <= perf_grant_o[gnt_idx] + LU_PERF_W'(1);
      end
   end
`endif

endmodule : logic_unit_arbiter

// File: tb/tb_logic_unit_arbiter.sv
// Purpose : directed self-checking bench for logic_unit_arbiter (4 requesters, 32-bit).
// Latency : results checked one cycle after each accepted request.
// Backpressure : exercises held results with the consumer stalled, then same-cycle drain/refill.
module tb_logic_unit_arbiter;

   logic                 clk_i = 1'b0;
   logic                 rst_n_i;
   logic [3:0]           req_valid_i;
   logic [3:0]           req_ready_o;
   logic [3:0][1:0]      req_op_i;
   logic [3:0][31:0]     req_a_i;
   logic [3:0][31:0]     req_b_i;
   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [31:0]          rsp_data_o;
   logic [1:0]           rsp_id_o;
`ifdef LOGIC_ARB_PERF_EN
   logic [3:0][15:0]     perf_grant_o;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk_i = ~clk_i;

   logic_unit_arbiter #(
      .N_REQ  (4),
      .DATA_W (32)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_op_i    (req_op_i),
      .req_a_i     (req_a_i),
      .req_b_i     (req_b_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_id_o    (rsp_id_o)
`ifdef LOGIC_ARB_PERF_EN
      ,
      .perf_grant_o (perf_grant_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_n_i     = 1'b0;
      req_valid_i = 4'hF;
      rsp_ready_i = 1'b1;
      req_op_i    = '0;
      req_a_i     = '1;
      req_b_i     = '1;
      repeat (2) tick();
      n_checks++;
      if (rsp_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", rsp_valid_o); else n_pass++;
      n_checks++;
      if (rsp_data_o !== 32'h0) $display("FAIL reset_data got %h want 00000000", rsp_data_o); else n_pass++;
      n_checks++;
      if (rsp_id_o !== 2'd0) $display("FAIL reset_id got %0d want 0", rsp_id_o); else n_pass++;
      n_checks++;
      if (req_ready_o !== 4'b0000) $display("FAIL reset_ready got %b want 0000", req_ready_o); else n_pass++;
      req_valid_i = 4'h0;
      #1 rst_n_i = 1'b1;
      req_valid_i = 4'hF;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0001) $display("FAIL reset_ptr_zero got %b want 0001", req_ready_o); else n_pass++;
      req_valid_i = 4'h0;
      tick();
   endtask

   task automatic test_single();
      rsp_ready_i = 1'b0;
      req_op_i[0] = 2'b01;
      req_a_i[0]  = 32'h0000FFFF;
      req_b_i[0]  = 32'hFFFF0000;
      req_valid_i = 4'b0001;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0001) $display("FAIL single_ready got %b want 0001", req_ready_o); else n_pass++;
      tick();
      req_valid_i = 4'b0000;
      n_checks++;
      if (rsp_valid_o !== 1'b1) $display("FAIL single_valid got %b want 1", rsp_valid_o); else n_pass++;
      n_checks++;
      if (rsp_data_o !== 32'hFFFFFFFF) $display("FAIL single_data got %h want ffffffff", rsp_data_o); else n_pass++;
      n_checks++;
      if (rsp_id_o !== 2'd0) $display("FAIL single_id got %0d want 0", rsp_id_o); else n_pass++;
      rsp_ready_i = 1'b1;
      tick();
      n_checks++;
      if (rsp_valid_o !== 1'b0) $display("FAIL single_drain got %b want 0", rsp_valid_o); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_a [4];
      logic [3:0]  exp_rdy;
      int          g;
      exp_a[0] = 32'h11111111;
      exp_a[1] = 32'h22222222;
      exp_a[2] = 32'h33333333;
      exp_a[3] = 32'h44444444;
      for (int i = 0; i < 4; i++) begin
         req_op_i[i] = 2'b00;
         req_a_i[i]  = exp_a[i];
         req_b_i[i]  = 32'hFFFFFFFF;
      end
      // Pointer is at 1 after the single request; one grant to req3 wraps it to 0
      rsp_ready_i = 1'b1;
      req_valid_i = 4'b1000;
      tick();
      n_checks++;
      if (rsp_id_o !== 2'd3) $display("FAIL rr_prefix_id got %0d want 3", rsp_id_o); else n_pass++;
      req_valid_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g       = k % 4;
         exp_rdy = 4'b0001 << g;
         #1;
         n_checks++;
         if (req_ready_o !== exp_rdy) $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready_o, exp_rdy); else n_pass++;
         tick();
         n_checks++;
         if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'(g) || rsp_data_o !== exp_a[g])
            $display("FAIL rr_result[%0d] got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                     k, rsp_valid_o, rsp_id_o, rsp_data_o, g, exp_a[g]);
         else n_pass++;
      end
      req_valid_i = 4'b0000;
      tick();
      n_checks++;
      if (rsp_valid_o !== 1'b0) $display("FAIL rr_drain_valid got %b want 0", rsp_valid_o); else n_pass++;
      n_checks++;
      if (rsp_data_o !== 32'h11111111) $display("FAIL rr_drain_hold got %h want 11111111", rsp_data_o); else n_pass++;
   endtask

   task automatic test_backpressure();
      rsp_ready_i = 1'b0;
      req_op_i[1] = 2'b10;
      req_a_i[1]  = 32'hF0F0F0F0;
      req_b_i[1]  = 32'hFF00FF00;
      req_valid_i = 4'b0010;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0010) $display("FAIL bp_first_ready got %b want 0010", req_ready_o); else n_pass++;
      tick();
      req_op_i[2] = 2'b11;
      req_a_i[2]  = 32'h000000FF;
      req_b_i[2]  = 32'h00000F00;
      req_valid_i = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (req_ready_o !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", c, req_ready_o); else n_pass++;
         tick();
         n_checks++;
         if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd1 || rsp_data_o !== 32'h0FF00FF0)
            $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h want v=1 id=1 d=0ff00ff0",
                     c, rsp_valid_o, rsp_id_o, rsp_data_o);
         else n_pass++;
      end
      rsp_ready_i = 1'b1;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0100) $display("FAIL bp_refill_ready got %b want 0100", req_ready_o); else n_pass++;
      tick();
      req_valid_i = 4'b0000;
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_data_o !== 32'hFFFFF000)
         $display("FAIL bp_refill got v=%b id=%0d d=%h want v=1 id=2 d=fffff000",
                  rsp_valid_o, rsp_id_o, rsp_data_o);
      else n_pass++;
      tick();
   endtask

   task automatic test_all_ops();
      logic [31:0] exp_d [4];
      exp_d[0] = 32'h12141218;
      exp_d[1] = 32'hFEFCFEF8;
      exp_d[2] = 32'hECE8ECE0;
      exp_d[3] = 32'h01030107;
      rsp_ready_i = 1'b1;
      req_a_i[0]  = 32'h12345678;
      req_b_i[0]  = 32'hFEDCBA98;
      req_valid_i = 4'b0001;
      for (int op = 0; op < 4; op++) begin
         req_op_i[0] = 2'(op);
         #1;
         n_checks++;
         if (req_ready_o !== 4'b0001) $display("FAIL ops_ready[%0d] got %b want 0001", op, req_ready_o); else n_pass++;
         tick();
         n_checks++;
         if (rsp_data_o !== exp_d[op] || rsp_id_o !== 2'd0)
            $display("FAIL ops_data[%0d] got id=%0d d=%h want id=0 d=%h", op, rsp_id_o, rsp_data_o, exp_d[op]);
         else n_pass++;
      end
      req_valid_i = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_ready_i = 1'b0;
      req_valid_i = 4'b0010;
      tick();
      req_valid_i = 4'b0000;
      n_checks++;
      if (rsp_valid_o !== 1'b1) $display("FAIL rmid_full got %b want 1", rsp_valid_o); else n_pass++;
      #3 rst_n_i = 1'b0;
      req_valid_i = 4'hF;
      #1;
      n_checks++;
      if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0 || rsp_id_o !== 2'd0)
         $display("FAIL rmid_clear got v=%b id=%0d d=%h want v=0 id=0 d=00000000",
                  rsp_valid_o, rsp_id_o, rsp_data_o);
      else n_pass++;
      n_checks++;
      if (req_ready_o !== 4'b0000) $display("FAIL rmid_ready got %b want 0000", req_ready_o); else n_pass++;
      req_valid_i = 4'h0;
      repeat (2) tick();
      #1 rst_n_i = 1'b1;
      req_valid_i = 4'hF;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0001) $display("FAIL rmid_ptr_reset got %b want 0001", req_ready_o); else n_pass++;
      req_valid_i = 4'b0100;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b0100) $display("FAIL rmid_req2_ready got %b want 0100", req_ready_o); else n_pass++;
      tick();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2)
         $display("FAIL rmid_req2 got v=%b id=%0d want v=1 id=2", rsp_valid_o, rsp_id_o);
      else n_pass++;
      rsp_ready_i = 1'b1;
      req_valid_i = 4'hF;
      #1;
      n_checks++;
      if (req_ready_o !== 4'b1000) $display("FAIL rmid_ptr3 got %b want 1000", req_ready_o); else n_pass++;
      req_valid_i = 4'h0;
      tick();
   endtask

`ifdef LOGIC_ARB_PERF_EN
   task automatic test_perf();
      #2 rst_n_i = 1'b0;
      #2 rst_n_i = 1'b1;
      rsp_ready_i = 1'b1;
      req_valid_i = 4'b0010;
      repeat (10) tick();
      req_valid_i = 4'b0000;
      tick();
      n_checks++;
      if (perf_grant_o[1] !== 16'd10) $display("FAIL perf_req1 got %0d want 10", perf_grant_o[1]); else n_pass++;
      n_checks++;
      if (perf_grant_o[0] !== 16'd0 || perf_grant_o[2] !== 16'd0 || perf_grant_o[3] !== 16'd0)
         $display("FAIL perf_others got %0d/%0d/%0d want 0/0/0",
                  perf_grant_o[0], perf_grant_o[2], perf_grant_o[3]);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_all_ops();
      test_reset_mid();
`ifdef LOGIC_ARB_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_logic_unit_arbiter
